// File: rtl/gc_scan_pkg.sv
// -----------------------------------------------------------------------------
// gc_scan_pkg
// Shared definitions for the GC scan-chain loader:
//   - state_t       : loader FSM states (IDLE, SHIFT, FLUSH)
//   - cnt_w()       : counter width for a counter that must hold 0..max_val
//   - CRC16_POLY    : CRC-16/CCITT polynomial (0x1021)
//   - CRC16_INIT    : CRC-16/CCITT initial value (0xFFFF)
//   - crc16_step()  : one serial CRC-16/CCITT update, MSB-first register
// -----------------------------------------------------------------------------
package gc_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Width needed to count 0..max_val; never narrower than one bit so that
    // degenerate parameter choices (CHAIN_LEN=1) still elaborate.
    function automatic int cnt_w(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    // Feed one serial bit into the CRC register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/gc_scan_word_buf.sv
// -----------------------------------------------------------------------------
// gc_scan_word_buf
// One-entry valid/ready holding register used for the readback word.
// A new word is accepted when the entry is empty or is being drained in the
// same cycle, so back-to-back words flow without a bubble.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : word offered by the collect register
//   in_ready            : entry can take in_data this cycle
//   out_data/out_valid  : held word towards the consumer (data zero after reset)
//   out_ready           : consumer accepts out_data
// -----------------------------------------------------------------------------
module gc_scan_word_buf #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    // The entry frees up in the same cycle the consumer takes it.
    always_comb begin
        in_ready = !out_valid || out_ready;
    end

    // Load on a handshake at the input, otherwise drop valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gc_scan_loader.sv
// -----------------------------------------------------------------------------
// gc_scan_loader
// Host-side driver for the GC flip-flop scan chain. A load pass serializes
// ceil(CHAIN_LEN/WORD_W) configuration words onto scan_si (LSB first) while
// capturing the old chain contents from scan_so into readback words.
//
// Optional feature (macro GC_SCAN_LOADER_CRC_EN):
//   adds output crc16, a CRC-16/CCITT (poly 0x1021, init 0xFFFF) over the
//   readback bits in capture order; valid on the done cycle, held until the
//   next start, cleared by R.
//
// Ports:
//   C, R                : clock (also clocks the chain), sync active-high reset
//   start               : begin a pass, only honoured in IDLE
//   wr_data/wr_valid    : configuration word, LSB shifted first
//   wr_ready            : a word is accepted this cycle
//   rd_data/rd_valid    : readback word, first captured bit at LSB
//   rd_ready            : downstream accepts rd_data
//   scan_se, scan_si    : chain scan enable / serial input
//   scan_e              : chain functional enable, tied low
//   scan_so             : serial output of the last chain flip-flop
//   busy, done          : pass in progress / single-cycle end-of-pass pulse
// -----------------------------------------------------------------------------
module gc_scan_loader
    import gc_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              C,
    input  logic              R,
    input  logic              start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              scan_se,
    output logic              scan_si,
    output logic              scan_e,
    input  logic              scan_so,
    output logic              busy,
    output logic              done
`ifdef GC_SCAN_LOADER_CRC_EN
    ,
    output logic [15:0]       crc16
`endif
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int BIT_W     = cnt_w(CHAIN_LEN - 1);
    localparam int WCNT_W    = cnt_w(NWORDS);
    localparam int FILL_W    = cnt_w(WORD_W);

    state_t state, state_nxt;

    logic [WORD_W-1:0] in_sr;
    logic [FILL_W-1:0] in_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] col_sr;
    logic [FILL_W-1:0] cap_cnt;
    logic              col_final;

    logic              in_empty;
    logic              words_owed;
    logic              col_full;
    logic              col_empty;
    logic              shift_en;
    logic              last_bit;
    logic              wr_fire;
    logic              start_pass;
    logic              buf_in_ready;
    logic              col_move;
    logic [FILL_W-1:0] fill_next;

    // Status decode of the input and collect registers. A shift needs a bit to
    // send and room to catch the bit coming back, so the chain only moves when
    // both sides can take part; otherwise it simply holds.
    always_comb begin
        in_empty   = (in_cnt == '0);
        words_owed = (word_cnt != WCNT_W'(NWORDS));
        col_full   = (cap_cnt == FILL_W'(WORD_W)) || col_final;
        col_empty  = (cap_cnt == '0) && !col_final;
        shift_en   = (state == SHIFT) && !in_empty && !col_full;
        last_bit   = (bit_cnt == BIT_W'(CHAIN_LEN - 1));
        wr_fire    = wr_ready && wr_valid;
        start_pass = (state == IDLE) && start;
        col_move   = col_full && buf_in_ready;
        fill_next  = (word_cnt == WCNT_W'(NWORDS - 1)) ? FILL_W'(LAST_BITS) : FILL_W'(WORD_W);
    end

    // State register.
    always_ff @(posedge C) begin
        if (R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the chain-facing outputs. scan_se/scan_si come straight
    // from registered state so the chain sees them well before the edge that
    // also samples scan_so.
    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        scan_se   = 1'b0;
        scan_si   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                wr_ready = in_empty && words_owed;
                if (shift_en) begin
                    scan_se = 1'b1;
                    scan_si = in_sr[0];
                    if (last_bit) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (col_empty && !rd_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        scan_e = 1'b0;
    end

    // Input side: a word is loaded only into an empty shift register, and only
    // the bits that still fit in the chain are counted as valid, so the upper
    // bits of a partial final word are never shifted out.
    always_ff @(posedge C) begin
        if (R) begin
            in_sr    <= '0;
            in_cnt   <= '0;
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_pass) begin
            in_cnt   <= '0;
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (wr_fire) begin
                in_sr    <= wr_data;
                in_cnt   <= fill_next;
                word_cnt <= word_cnt + WCNT_W'(1);
            end else if (shift_en) begin
                in_sr  <= in_sr >> 1;
                in_cnt <= in_cnt - FILL_W'(1);
            end
            if (shift_en && !last_bit) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Collect side: scan_so lands at bit cap_cnt on each shift edge. The
    // register is cleared when it hands its word over, which leaves the unused
    // upper bits of a short final word at zero. Handover and shifting never
    // coincide because a full collect register blocks shifting.
    always_ff @(posedge C) begin
        if (R) begin
            col_sr    <= '0;
            cap_cnt   <= '0;
            col_final <= 1'b0;
        end else if (start_pass || col_move) begin
            col_sr    <= '0;
            cap_cnt   <= '0;
            col_final <= 1'b0;
        end else if (shift_en) begin
            col_sr  <= col_sr | (WORD_W'(scan_so) << cap_cnt);
            cap_cnt <= cap_cnt + FILL_W'(1);
            if (last_bit) begin
                col_final <= 1'b1;
            end
        end
    end

    gc_scan_word_buf #(
        .WORD_W (WORD_W)
    ) u_rd_buf (
        .clk       (C),
        .rst       (R),
        .in_data   (col_sr),
        .in_valid  (col_full),
        .in_ready  (buf_in_ready),
        .out_data  (rd_data),
        .out_valid (rd_valid),
        .out_ready (rd_ready)
    );

`ifdef GC_SCAN_LOADER_CRC_EN
    // Running CRC over captured bits: seeded when a pass starts, stepped on
    // every shift edge with the bit being captured, then left alone so the
    // final value stays readable after done.
    always_ff @(posedge C) begin
        if (R) begin
            crc16 <= '0;
        end else if (start_pass) begin
            crc16 <= CRC16_INIT;
        end else if (shift_en) begin
            crc16 <= crc16_step(crc16, scan_so);
        end
    end
`endif

endmodule

// File: tb/tb_gc_scan_loader.sv
// -----------------------------------------------------------------------------
// tb_gc_scan_loader
// Three loader instances (16x8, 12x8, 64x8) share one behavioural scan chain;
// only the selected instance is ever started. Expected chain contents,
// readback words and CRC come from the preloaded chain value and the written
// words, with no reference to the loader's internals.
// -----------------------------------------------------------------------------
module tb_gc_scan_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       wr_valid = 1'b0;
    logic       rd_ready = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] sel = 2'd2;

    logic       s_start    [3];
    logic       s_wr_valid [3];
    logic       s_wr_ready [3];
    logic [7:0] s_rd_data  [3];
    logic       s_rd_valid [3];
    logic       s_se       [3];
    logic       s_si       [3];
    logic       s_e        [3];
    logic       s_busy     [3];
    logic       s_done     [3];
`ifdef GC_SCAN_LOADER_CRC_EN
    logic [15:0] s_crc     [3];
    logic [15:0] m_crc;
`endif

    logic       m_wr_ready, m_rd_valid, m_se, m_si, m_e, m_busy, m_done;
    logic [7:0] m_rd_data;
    int         clen;

    logic [63:0] chain;
    logic [63:0] load_val = '0;
    logic        load_req = 1'b0;

    logic [7:0] wq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Route the shared stimulus to the selected instance and bring its
    // outputs back out.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            s_start[k]    = start && (sel == 2'(k));
            s_wr_valid[k] = wr_valid && (sel == 2'(k));
        end
        m_wr_ready = s_wr_ready[sel];
        m_rd_valid = s_rd_valid[sel];
        m_rd_data  = s_rd_data[sel];
        m_se       = s_se[sel];
        m_si       = s_si[sel];
        m_e        = s_e[sel];
        m_busy     = s_busy[sel];
        m_done     = s_done[sel];
`ifdef GC_SCAN_LOADER_CRC_EN
        m_crc      = s_crc[sel];
`endif
        case (sel)
            2'd0:    clen = 16;
            2'd1:    clen = 12;
            default: clen = 64;
        endcase
    end

    gc_scan_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
        .C(clk), .R(rst), .start(s_start[0]), .wr_data(wr_data),
        .wr_valid(s_wr_valid[0]), .wr_ready(s_wr_ready[0]),
        .rd_data(s_rd_data[0]), .rd_valid(s_rd_valid[0]), .rd_ready(rd_ready),
        .scan_se(s_se[0]), .scan_si(s_si[0]), .scan_e(s_e[0]), .scan_so(chain[0]),
        .busy(s_busy[0]), .done(s_done[0])
`ifdef GC_SCAN_LOADER_CRC_EN
        , .crc16(s_crc[0])
`endif
    );

    gc_scan_loader #(.CHAIN_LEN(12), .WORD_W(8)) u12 (
        .C(clk), .R(rst), .start(s_start[1]), .wr_data(wr_data),
        .wr_valid(s_wr_valid[1]), .wr_ready(s_wr_ready[1]),
        .rd_data(s_rd_data[1]), .rd_valid(s_rd_valid[1]), .rd_ready(rd_ready),
        .scan_se(s_se[1]), .scan_si(s_si[1]), .scan_e(s_e[1]), .scan_so(chain[0]),
        .busy(s_busy[1]), .done(s_done[1])
`ifdef GC_SCAN_LOADER_CRC_EN
        , .crc16(s_crc[1])
`endif
    );

    gc_scan_loader #(.CHAIN_LEN(64), .WORD_W(8)) u64 (
        .C(clk), .R(rst), .start(s_start[2]), .wr_data(wr_data),
        .wr_valid(s_wr_valid[2]), .wr_ready(s_wr_ready[2]),
        .rd_data(s_rd_data[2]), .rd_valid(s_rd_valid[2]), .rd_ready(rd_ready),
        .scan_se(s_se[2]), .scan_si(s_si[2]), .scan_e(s_e[2]), .scan_so(chain[0]),
        .busy(s_busy[2]), .done(s_done[2])
`ifdef GC_SCAN_LOADER_CRC_EN
        , .crc16(s_crc[2])
`endif
    );

    // Behavioural scan chain: bit 0 is the last flip-flop (drives scan_so),
    // bit clen-1 is the first flip-flop (takes scan_si).
    always @(posedge clk) begin
        if (load_req) begin
            chain <= load_val;
        end else if (m_se === 1'b1) begin
            for (int i = 0; i < 63; i++) begin
                chain[i] <= (i == clen - 1) ? m_si : chain[i + 1];
            end
            chain[63] <= (clen == 64) ? m_si : chain[63];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic loadChain(input logic [63:0] v);
        @(negedge clk);
        load_val = v;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // CRC-16/CCITT over the old chain bits in the order they leave the chain.
    function automatic logic [15:0] refCrc(input logic [63:0] bits, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = (c[15] ^ bits[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic fillWords(input int n);
        wq.delete();
        for (int k = 0; k < n; k++) begin
            wq.push_back(8'($urandom));
        end
    endtask

    // One load pass on instance 'which' with the words in wq.
    task automatic applyStimulus(input logic [1:0] which, input int gap, input int stall_at,
                                 input int stall_len, input bit stall_chk, input int rst_after,
                                 input int start_hold);
        logic [63:0] old_v, exp_new, mask, snap, g;
        logic [7:0]  got[$];
        logic [7:0]  pend_data;
        logic [15:0] exp_crc;
        int len, nw, wi, gap_left, cyc, se_cnt, done_cnt;
        int first_acc, first_se, last_se, shift_empty, late_se;
        bit finished, pend;
        sel = which; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
        @(negedge clk); #1;
        len  = clen;
        nw   = (len + 7) / 8;
        mask = (len == 64) ? '1 : ((64'd1 << len) - 64'd1);
        old_v = chain & mask;
        exp_new = '0;
        for (int k = 0; k < nw; k++) begin
            exp_new |= 64'(wq[k]) << (8 * k);
        end
        exp_new &= mask;
        exp_crc = refCrc(old_v, len);
        wi = 0; gap_left = 0; cyc = 0; se_cnt = 0; done_cnt = 0;
        first_acc = -1; first_se = -1; last_se = -1; shift_empty = 0; late_se = 0;
        finished = 1'b0; pend = 1'b0; pend_data = '0; snap = '0;
        while (!finished && cyc < 400) begin
            if (rst_after >= 0 && se_cnt == rst_after) begin
                rst = 1'b1; start = 1'b0; wr_valid = 1'b0;
                @(negedge clk); #1;
                rst = 1'b0;
                checkOutput("midrst_busy", m_busy, 0);
                checkOutput("midrst_se", m_se, 0);
                checkOutput("midrst_rd_valid", m_rd_valid, 0);
                return;
            end
            start = (cyc < start_hold);
            if (wi < nw && gap_left == 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[wi];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
            end
            rd_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (pend) begin
                checkOutput("rd_hold", {m_rd_valid, m_rd_data}, {1'b1, pend_data});
            end
            pend      = m_rd_valid && !rd_ready;
            pend_data = m_rd_data;
            if (m_se) begin
                se_cnt++;
                if (first_se < 0) first_se = cyc;
                last_se = cyc;
                if (m_wr_ready) shift_empty++;
            end
            if (stall_chk) begin
                if (cyc == stall_at + stall_len - 4) snap = chain;
                if (cyc >= stall_at + stall_len - 4 && cyc < stall_at + stall_len && m_se) late_se++;
                if (cyc == stall_at + stall_len - 1) checkOutput("stall_chain_hold", chain, snap);
            end
            if (m_rd_valid && rd_ready) got.push_back(m_rd_data);
            if (wr_valid && m_wr_ready) begin
                if (first_acc < 0) first_acc = cyc;
                wi++;
                gap_left = gap;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (m_done) begin
                done_cnt++;
                finished = 1'b1;
`ifdef GC_SCAN_LOADER_CRC_EN
                checkOutput("crc16", m_crc, exp_crc);
`endif
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        wr_valid = 1'b0; start = 1'b0; rd_ready = 1'b1;
        checkOutput("pass_completed", finished, 1);
        checkOutput("done_pulse_off", {m_done, m_busy}, 0);
        checkOutput("se_count", se_cnt, len);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("rd_word_count", got.size(), nw);
        for (int k = 0; k < nw; k++) begin
            g = (k < got.size()) ? 64'(got[k]) : 'x;
            checkOutput("rd_word", g, (old_v >> (8 * k)) & 64'hFF);
        end
        checkOutput("chain_final", chain & mask, exp_new);
        checkOutput("first_shift_latency", first_se - first_acc, 1);
        checkOutput("shift_without_data", shift_empty, 0);
        if (gap == 0 && stall_len == 0) begin
            checkOutput("throughput", last_se - first_se, len - 1 + nw - 1);
        end
        if (stall_chk) begin
            checkOutput("stall_se_low", late_se, 0);
        end
    endtask

    initial begin
        // Reset with start also high: reset must win and all outputs idle.
        rst = 1'b1; start = 1'b1; sel = 2'd2;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_outputs",
                        {s_wr_ready[k], s_rd_valid[k], s_rd_data[k], s_se[k], s_si[k],
                         s_e[k], s_busy[k], s_done[k]}, 0);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_after_rst", m_busy, 0);

        $display("[TB] 16-bit chain, preload 0xBEEF, write 0x34 0x12");
        loadChain(64'hBEEF);
        wq = '{8'h34, 8'h12};
        applyStimulus(2'd0, 0, 0, 0, 1'b0, -1, 1);

        $display("[TB] 12-bit chain, partial final word");
        loadChain(64'h0);
        wq = '{8'hFF, 8'hAB};
        applyStimulus(2'd1, 0, 0, 0, 1'b0, -1, 1);

        $display("[TB] 64-bit chain, readback stalled for 20 cycles");
        loadChain({$urandom, $urandom});
        fillWords(8);
        applyStimulus(2'd2, 0, 3, 20, 1'b1, -1, 1);

        $display("[TB] 64-bit chain, 3-cycle write gaps, start held while busy");
        loadChain({$urandom, $urandom});
        fillWords(8);
        applyStimulus(2'd2, 3, 0, 0, 1'b0, -1, 6);

        $display("[TB] reset after 5 shifts, then a full pass");
        loadChain({$urandom, $urandom});
        fillWords(8);
        applyStimulus(2'd2, 0, 0, 0, 1'b0, 5, 1);
        fillWords(8);
        applyStimulus(2'd2, 0, 0, 0, 1'b0, -1, 1);

        $display("[TB] readback of ASCII 0x31..0x38");
        loadChain(64'h3837363534333231);
        fillWords(8);
        applyStimulus(2'd2, 0, 0, 0, 1'b0, -1, 1);

        $display("[TB] randomized passes");
        for (int t = 0; t < 6; t++) begin
            logic [1:0] w;
            w = 2'($urandom_range(0, 2));
            sel = w;
            @(negedge clk); #1;
            loadChain({$urandom, $urandom});
            fillWords((clen + 7) / 8);
            applyStimulus(w, $urandom_range(0, 2), $urandom_range(0, 30),
                          $urandom_range(0, 15), 1'b0, -1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
